// File: rtl/simps_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simps_pkg: shared types and constants for the SIMPS transmit path.
// Revision: 1.0
// ---------------------------------------------------------------------------
package simps_pkg;

  localparam int TX_LEN_W = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_picker: combinational round-robin pick, first request at or after rr_ptr.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic                       valid
);

  // Scan offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    int w_idx;
    w_idx = 0;
    pick  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = int'(rr_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (req[w_idx]) begin
        pick        = '0;
        pick[w_idx] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_tx_arbiter: packet-atomic round-robin arbiter for the FT245 write port.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_tx_arbiter
  import simps_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = TX_LEN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] len,
  input  logic [NUM_REQ*8-1:0]     data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic                     wr_en,
  output logic [7:0]               wr_data,
  input  logic                     wr_full
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]   r_gidx, w_gidx_nxt, w_pick_idx;
  logic [LEN_W-1:0]   r_remaining, w_remaining_nxt, w_pick_len;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_pick_valid;
  logic               w_send;
  byte_t              w_sel_byte;

  function automatic logic [PTR_W-1:0] ptr_succ(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .pick   (w_pick),
    .valid  (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  assign w_pick_len = len[w_pick_idx*LEN_W +: LEN_W];
  assign w_sel_byte = data[r_gidx*8 +: 8];

  // Write-side datapath is combinational from state and wr_full only.
  assign w_send  = (r_state == ARB_SEND);
  assign wr_en   = w_send & ~wr_full;
  assign wr_data = w_send ? w_sel_byte : 8'h00;
  assign ack     = wr_en ? r_grant : '0;
  assign grant   = r_grant;
  assign done    = r_done;

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gidx_nxt      = r_gidx;
    w_remaining_nxt = r_remaining;
    w_grant_nxt     = r_grant;
    w_done_nxt      = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          if (w_pick_len == '0) begin
            // Empty packet: retire it without ever granting the write port.
            w_done_nxt   = w_pick;
            w_rr_ptr_nxt = ptr_succ(w_pick_idx);
          end else begin
            w_grant_nxt     = w_pick;
            w_gidx_nxt      = w_pick_idx;
            w_remaining_nxt = w_pick_len;
            w_state_nxt     = ARB_SEND;
          end
        end
      end
      ARB_SEND: begin
        if (wr_en) begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            w_done_nxt   = r_grant;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = ptr_succ(r_gidx);
            w_state_nxt  = ARB_GAP;
          end
        end
      end
      ARB_GAP: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_gidx      <= '0;
      r_remaining <= '0;
      r_grant     <= '0;
      r_done      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gidx      <= w_gidx_nxt;
      r_remaining <= w_remaining_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_tx_arbiter: directed self-checking bench for fifo_tx_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fifo_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] len;
  logic [15:0] data;
  logic [1:0]  grant, ack, done;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_full;

  int checks   = 0;
  int failures = 0;

  // Requester byte stores; each pointer advances on its ack.
  logic [7:0] mem [0:1][0:255];
  logic [7:0] p0, p1;
  logic       clr_ptr;

  // Observation vector: grant, ack, done, wr_en, wr_data.
  logic [14:0] obs;
  assign obs  = {grant, ack, done, wr_en, wr_data};
  assign data = {mem[1][p1], mem[0][p0]};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset || clr_ptr) begin
      p0 <= 8'd0;
      p1 <= 8'd0;
    end else begin
      if (ack[0]) p0 <= p0 + 8'd1;
      if (ack[1]) p1 <= p1 + 8'd1;
    end
  end

  fifo_tx_arbiter #(
    .NUM_REQ (2),
    .LEN_W   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .data    (data),
    .grant   (grant),
    .ack     (ack),
    .done    (done),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_full (wr_full)
  );

  function automatic logic [14:0] ev(input logic [1:0] g, input logic [1:0] a,
                                     input logic [1:0] d, input logic w,
                                     input logic [7:0] b);
    return {g, a, d, w, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ptrs();
    clr_ptr = 1'b1;
    tick();
    clr_ptr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if (obs !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 15'h0);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 15'h0) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", obs, 15'h0);
    end
  endtask

  task automatic test_single();
    logic [14:0] ex [0:5];
    logic [1:0]  rq [0:5];
    logic [14:0] mask;
    mem[0][0] = 8'hAA; mem[0][1] = 8'hBB; mem[0][2] = 8'hCC;
    clear_ptrs();
    len = {8'd0, 8'd3};
    req = 2'b01;
    rq = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    ex = '{ev(2'b01, 2'b01, 2'b00, 1'b1, 8'hAA),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'hBB),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'hCC),
           ev(2'b00, 2'b00, 2'b01, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00)};
    for (int c = 0; c < 6; c++) begin
      tick();
      req = rq[c];
      #1;
      mask = ex[c][8] ? 15'h7fff : 15'h7f00;
      checks++;
      if ((obs & mask) !== (ex[c] & mask)) begin
        failures++;
        $display("FAIL single c%0d: got %h expected %h", c, obs, ex[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [14:0] ex [0:8];
    logic [1:0]  rq [0:8];
    logic        fl [0:8];
    logic [14:0] mask;
    clear_ptrs();
    len = {8'd0, 8'd3};
    req = 2'b01;
    rq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    fl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ex = '{ev(2'b01, 2'b01, 2'b00, 1'b1, 8'hAA),
           ev(2'b01, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b01, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b01, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b01, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'hBB),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'hCC),
           ev(2'b00, 2'b00, 2'b01, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00)};
    for (int c = 0; c < 9; c++) begin
      tick();
      req     = rq[c];
      wr_full = fl[c];
      #1;
      mask = ex[c][8] ? 15'h7fff : 15'h7f00;
      checks++;
      if ((obs & mask) !== (ex[c] & mask)) begin
        failures++;
        $display("FAIL backpressure c%0d: got %h expected %h", c, obs, ex[c]);
      end
    end
  endtask

  // The previous packet went to requester 0, so the pointer sits at 1 here.
  task automatic test_zero_length();
    logic [14:0] ex [0:2];
    len = {8'd0, 8'd3};
    req = 2'b10;
    ex = '{ev(2'b00, 2'b00, 2'b10, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00)};
    for (int c = 0; c < 3; c++) begin
      tick();
      req = 2'b00;
      #1;
      checks++;
      if ((obs & 15'h7f00) !== ex[c]) begin
        failures++;
        $display("FAIL zero_length c%0d: got %h expected %h", c, obs, ex[c]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [14:0] ex [0:16];
    logic [14:0] mask;
    for (int i = 0; i < 4; i++) begin
      mem[0][i] = 8'h10 + 8'(i);
      mem[1][i] = 8'h20 + 8'(i);
    end
    clear_ptrs();
    len = {8'd2, 8'd2};
    req = 2'b11;
    ex = '{ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h10),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h11),
           ev(2'b00, 2'b00, 2'b01, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b10, 2'b10, 2'b00, 1'b1, 8'h20),
           ev(2'b10, 2'b10, 2'b00, 1'b1, 8'h21),
           ev(2'b00, 2'b00, 2'b10, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h12),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h13),
           ev(2'b00, 2'b00, 2'b01, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b10, 2'b10, 2'b00, 1'b1, 8'h22),
           ev(2'b10, 2'b10, 2'b00, 1'b1, 8'h23),
           ev(2'b00, 2'b00, 2'b10, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00)};
    for (int c = 0; c < 17; c++) begin
      tick();
      req = (c >= 14) ? 2'b00 : 2'b11;
      #1;
      mask = ex[c][8] ? 15'h7fff : 15'h7f00;
      checks++;
      if ((obs & mask) !== (ex[c] & mask)) begin
        failures++;
        $display("FAIL fairness c%0d: got %h expected %h", c, obs, ex[c]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [14:0] ex [0:10];
    logic        rs [0:10];
    logic [14:0] mask;
    for (int i = 0; i < 5; i++) mem[0][i] = 8'h30 + 8'(i);
    clear_ptrs();
    len = {8'd0, 8'd5};
    req = 2'b01;
    rs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ex = '{ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h30),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h31),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h30),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h31),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h32),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h33),
           ev(2'b01, 2'b01, 2'b00, 1'b1, 8'h34),
           ev(2'b00, 2'b00, 2'b01, 1'b0, 8'h00),
           ev(2'b00, 2'b00, 2'b00, 1'b0, 8'h00)};
    for (int c = 0; c < 11; c++) begin
      tick();
      reset = rs[c];
      req   = (c >= 9) ? 2'b00 : 2'b01;
      #1;
      mask = (ex[c][8] || rs[c]) ? 15'h7fff : 15'h7f00;
      checks++;
      if ((obs & mask) !== (ex[c] & mask)) begin
        failures++;
        $display("FAIL reset_mid_packet c%0d: got %h expected %h", c, obs, ex[c]);
      end
    end
  endtask

  task automatic test_max_length();
    int n_wr, n_done, last_wr, done_c;
    n_wr = 0; n_done = 0; last_wr = -1; done_c = -1;
    for (int i = 0; i < 256; i++) mem[0][i] = 8'(i);
    clear_ptrs();
    len = {8'd0, 8'd255};
    req = 2'b01;
    for (int c = 0; c < 300; c++) begin
      tick();
      #1;
      if (wr_en) begin
        checks++;
        if (wr_data !== 8'(n_wr)) begin
          failures++;
          $display("FAIL max_len_byte%0d: got %h expected %h", n_wr, wr_data, 8'(n_wr));
        end
        n_wr++;
        last_wr = c;
      end
      if (done[0]) begin
        n_done++;
        done_c = c;
        req = 2'b00;
      end
    end
    checks++;
    if (n_wr !== 255) begin
      failures++;
      $display("FAIL max_len_writes: got %0d expected %0d", n_wr, 255);
    end
    checks++;
    if (n_done !== 1) begin
      failures++;
      $display("FAIL max_len_done_count: got %0d expected %0d", n_done, 1);
    end
    checks++;
    if (done_c !== last_wr + 1) begin
      failures++;
      $display("FAIL max_len_done_cycle: got %0d expected %0d", done_c, last_wr + 1);
    end
  endtask

  initial begin
    reset   = 1'b1;
    req     = 2'b00;
    len     = 16'h0;
    wr_full = 1'b0;
    clr_ptr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 8'h00;
      mem[1][i] = 8'h00;
    end
    tick();
    test_reset();
    test_single();
    test_backpressure();
    test_zero_length();
    test_fairness();
    test_reset_mid_packet();
    test_max_length();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
